// File: rtl/rtc_bcd_timekeeper_pkg.sv
// Shared types, limits and hour-format helpers for the BCD time-of-day counter.
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX     = 59;
    localparam int MIN_MAX     = 59;
    localparam int HOUR_MAX_24 = 23;
    localparam int HOUR_NOON   = 12;

    // Two-digit BCD hour (00-23) to binary.
    function automatic logic [4:0] hour_bin(input bcd_t tens, input bcd_t ones);
        hour_bin = 5'(tens) * 5'd10 + 5'(ones);
    endfunction

    // Internal 24-hour BCD hour to the displayed BCD digit pair.
    function automatic logic [7:0] hour_display(input bcd_t tens, input bcd_t ones,
                                                input logic mode_12h);
        logic [4:0] h;
        logic [4:0] d;
        h = hour_bin(tens, ones);
        d = h;
        if (mode_12h) begin
            if (h == 5'd0)
                d = 5'(HOUR_NOON);
            else if (h > 5'(HOUR_NOON))
                d = h - 5'(HOUR_NOON);
        end
        if (d >= 5'd20)
            hour_display = {4'd2, 4'(d - 5'd20)};
        else if (d >= 5'd10)
            hour_display = {4'd1, 4'(d - 5'd10)};
        else
            hour_display = {4'd0, 4'(d)};
    endfunction

endpackage

// File: rtl/rtc_bcd_timekeeper_if.sv
// Control/display bundle of the time-of-day counter.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_bcd_timekeeper_if #(
    parameter int SEC_W = 6
);
    import rtc_pkg::*;

    logic             mode_12h;
    logic             set_en;
    logic             set_sel;
    logic             inc;
    bcd_t             hours_tens;
    bcd_t             hours_ones;
    bcd_t             mins_tens;
    bcd_t             mins_ones;
    logic [SEC_W-1:0] secs;
    logic             pm;
    logic             sec_pulse;
`ifdef RTC_ALARM_EN
    logic [7:0]       alarm_hh;
    logic [7:0]       alarm_mm;
    logic             alarm_arm;
    logic             alarm_ack;
    logic             alarm;

    modport master (
        output mode_12h, set_en, set_sel, inc, alarm_hh, alarm_mm, alarm_arm, alarm_ack,
        input  hours_tens, hours_ones, mins_tens, mins_ones, secs, pm, sec_pulse, alarm
    );
    modport slave (
        input  mode_12h, set_en, set_sel, inc, alarm_hh, alarm_mm, alarm_arm, alarm_ack,
        output hours_tens, hours_ones, mins_tens, mins_ones, secs, pm, sec_pulse, alarm
    );
`else
    modport master (
        output mode_12h, set_en, set_sel, inc,
        input  hours_tens, hours_ones, mins_tens, mins_ones, secs, pm, sec_pulse
    );
    modport slave (
        input  mode_12h, set_en, set_sel, inc,
        output hours_tens, hours_ones, mins_tens, mins_ones, secs, pm, sec_pulse
    );
`endif

endinterface

// File: rtl/rtc_bcd_timekeeper_bcd_wrap_counter.sv
// Two-digit BCD counter 00..MAX with wrap, carry-out on wrap and synchronous clear.
module bcd_wrap_counter
    import rtc_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);
    localparam bcd_t MAX_T = bcd_t'(MAX / 10);
    localparam bcd_t MAX_O = bcd_t'(MAX % 10);

    logic at_max;

    assign at_max = (tens == MAX_T) && (ones == MAX_O);
    assign carry  = en && at_max;

    // Advance the digit pair, wrapping MAX back to 00.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (en) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= '0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_bcd_timekeeper.sv
// BCD time-of-day counter: 1 s prescaler, 24-hour internal HH:MM, binary SS,
// registered 12/24-hour display, manual set mode and seconds strobe.
// Optional alarm compare is built when RTC_ALARM_EN is defined.
module rtc_bcd_timekeeper
    import rtc_pkg::*;
#(
    parameter int DIV_COUNT = 100000000,
    parameter int SEC_W     = 6
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    rtc_bcd_timekeeper_if.slave bus
);
    localparam int            PW   = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV_COUNT - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          set_inc;
    logic [5:0]    ss;
    logic          ss_wrap;
    logic          mm_en;
    logic          mm_carry;
    logic          hh_en;
    logic          hh_carry_unused;
    bcd_t          mm_tens, mm_ones;
    bcd_t          hh_tens, hh_ones;
    logic          vld_p0;

    // Set mode suppresses the tick even when the prescaler sits at terminal count.
    assign tick    = !bus.set_en && (presc == TERM);
    assign set_inc = bus.set_en && bus.inc;
    assign ss_wrap = (ss == 6'(SEC_MAX));

    // Minutes advance on a seconds wrap or a set-mode minute pulse; only the
    // tick path may carry into hours.
    assign mm_en = (tick && ss_wrap) || (set_inc && !bus.set_sel);
    assign hh_en = (tick && mm_carry) || (set_inc && bus.set_sel);

    // Prescaler: free-runs 0..DIV_COUNT-1, parked at 0 during set mode.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || bus.set_en || tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    // Binary seconds; any accepted set-mode pulse restarts the minute.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || set_inc)
            ss <= '0;
        else if (tick)
            ss <= ss_wrap ? 6'd0 : ss + 6'd1;
    end

    bcd_wrap_counter #(.MAX(MIN_MAX)) u_mm (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .clr   (1'b0),
        .en    (mm_en),
        .tens  (mm_tens),
        .ones  (mm_ones),
        .carry (mm_carry)
    );

    bcd_wrap_counter #(.MAX(HOUR_MAX_24)) u_hh (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .clr   (1'b0),
        .en    (hh_en),
        .tens  (hh_tens),
        .ones  (hh_ones),
        .carry (hh_carry_unused)
    );

    // ---- stage p0 -> p1: output register, strobe delayed to align with new secs ----
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            vld_p0                           <= 1'b0;
            {bus.hours_tens, bus.hours_ones} <= '0;
            bus.mins_tens                    <= '0;
            bus.mins_ones                    <= '0;
            bus.secs                         <= '0;
            bus.pm                           <= 1'b0;
            bus.sec_pulse                    <= 1'b0;
        end else begin
            vld_p0                           <= tick;
            {bus.hours_tens, bus.hours_ones} <= hour_display(hh_tens, hh_ones, bus.mode_12h);
            bus.mins_tens                    <= mm_tens;
            bus.mins_ones                    <= mm_ones;
            bus.secs                         <= SEC_W'(ss);
            bus.pm                           <= (hour_bin(hh_tens, hh_ones) >= 5'(HOUR_NOON));
            bus.sec_pulse                    <= vld_p0;
        end
    end

`ifdef RTC_ALARM_EN
    logic alarm_match;

    assign alarm_match = ({hh_tens, hh_ones} == bus.alarm_hh) &&
                         ({mm_tens, mm_ones} == bus.alarm_mm) && (ss == 6'd0);

    // Alarm latches on the tick that lands on HH:MM:00; ack or disarm clears it first.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || bus.alarm_ack || !bus.alarm_arm)
            bus.alarm <= 1'b0;
        else if (vld_p0 && alarm_match && !bus.set_en)
            bus.alarm <= 1'b1;
    end
`endif

endmodule

// File: doc/rtc_bcd_timekeeper.md
# rtc_bcd_timekeeper

Parametrised BCD time-of-day counter for the board clock display: divides the system clock to a 1 s tick and keeps HH:MM:SS in BCD. It supports run-time 12/24-hour display, manual time setting and a seconds strobe. It sits between the delayed-reset logic and the seven-segment driver, which consumes its four BCD digits. The seconds count drives the LEDs.

## Interface
Parameters:
- DIV_COUNT, 100000000, clock cycles per second tick; must be ≥ 2. Prescaler width is $clog2(DIV_COUNT).
- SEC_W, 6, width of binary seconds output.

Ports:
- CLK100MHZ  in  1  system clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- set_en  in  1  1 = set mode: timekeeping halted, prescaler held at 0.
- set_sel  in  1  set-mode target: 0 = minutes, 1 = hours.
- inc  in  1  single-cycle increment pulse; honoured only while set_en = 1.
- hours_tens, hours_ones, mins_tens, mins_ones  out  4 each  displayed BCD digits.
- secs  out  SEC_W  binary seconds, 0–59.
- pm  out  1  1 when internal hour ≥ 12; valid in both modes.
- sec_pulse  out  1  one-cycle strobe for each seconds advance.

## Operation
- Internal state is always 24-hour BCD (hh 00–23, mm 00–59) plus binary ss 0–59. The display format is derived at the output register.
- Prescaler counts 0..DIV_COUNT-1 while set_en = 0. The terminal count produces a tick and the prescaler returns to 0.
- On a tick, ss increments:
  - 59 → 0 carries into mm.
  - mm 59 → 00 carries into hh.
  - hh 23 → 00 wraps.
- Carries ripple within the same edge: 23:59:59 → 00:00:00 in one tick.
- 12-hour conversion:
  - hh 00 → 12.
  - hh 13–23 → hh-12.
  - hh 01–12 are shown unchanged.
  - The hours digit pair is BCD, so 10–12 show as tens = 1.
- Set mode (set_en = 1):
  - Prescaler is held at 0 and no ticks occur.
  - inc with set_sel = 0: mm +1, wrapping 59 → 00 with no carry into hh.
  - inc with set_sel = 1: hh +1, wrapping 23 → 00.
  - Every accepted inc clears ss to 0.
- When set_en falls, counting resumes with a full DIV_COUNT period before the next tick.
- mode_12h may change at any time. Internal time is unaffected; only the display changes.

## Timing
- All outputs are registered. Digits, secs and pm reflect internal state with a 1-cycle latency.
- sec_pulse is high for exactly the cycle in which the new secs value first appears on the outputs.
- A tick occurs every DIV_COUNT cycles exactly. Time spent in set mode is excluded from the count.
- Reset (any cycle, including mid-carry or in set mode):
  - Internal time becomes 00:00:00 and the prescaler becomes 0.
  - All outputs become 0 on the reset edge.
  - The first cycle after release shows 00:00 in 24-hour mode, or 12:00 with pm = 0 in 12-hour mode.
- An inc while set_en = 0 is ignored.
- If set_en rises in the same cycle as a terminal count, set_en wins and no tick occurs.

## Configuration
- Macro RTC_ALARM_EN adds the alarm feature.
- With RTC_ALARM_EN defined, the block has four additional ports:
  - inputs alarm_hh[7:0] and alarm_mm[7:0] (24-hour BCD),
  - input alarm_arm,
  - input alarm_ack,
  - output alarm.
- alarm sets one cycle after internal time becomes alarm_hh:alarm_mm:00 while alarm_arm = 1 and set_en = 0.
- Once set, alarm holds until alarm_ack = 1, alarm_arm = 0, or reset. Reset value of alarm is 0.
- If ack and match occur in the same cycle, ack wins.
- Without RTC_ALARM_EN, the alarm ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package rtc_pkg holds:
  - the BCD digit typedef (4-bit),
  - constants SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX_24 = 23, HOUR_NOON = 12.
- Sub-module bcd_wrap_counter: a two-digit BCD counter with parameter MAX, increment enable, carry-out on wrap, and synchronous clear. It is instantiated for mm and hh. ss stays binary inline.

## Test plan
Run all scenarios with DIV_COUNT = 4.
- Tick rate: reset, then run 12 cycles → secs = 3. sec_pulse is seen 3 times, each 4 cycles apart.
- Full rollover: set 23:59 and let ss reach 59, then one tick → 00:00:00 with pm = 0 in the cycle sec_pulse fires.
- 12-hour mode:
  - set hh = 00 → shows 12, pm = 0;
  - hh = 13 → shows 01, pm = 1;
  - toggling mode_12h mid-run leaves secs unchanged.
- Set mode:
  - set_en = 1, set_sel = 0, 61 inc pulses from 00 → mm = 01 and hh unchanged;
  - ss = 0 after inc;
  - no sec_pulse while set_en = 1.
- Reset mid-operation: assert reset at 10:45:30 during a tick cycle → outputs 0 the next cycle, then 00:00:00.
- RTC_ALARM_EN: alarm = 07:30, armed:
  - 07:29:59 plus one tick → alarm = 1 one cycle later;
  - alarm holds until alarm_ack;
  - with arm = 0, no assertion.
